// File: rtl/decode_stage.sv
// Instruction decode stage: field split, register file, writeback port, busy scoreboard
// and a registered valid/ready output. Define DECODE_WB_BYPASS_EN to forward writeback data.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_dst,
    output logic [XLEN-1:0] out_src1_val,
    output logic [XLEN-1:0] out_src2_val,
    output logic [9:0]      out_offsetlo,
    output logic [XLEN-1:0] out_imm,
    input  logic            wb_en,
    input  logic [4:0]      wb_dst,
    input  logic [XLEN-1:0] wb_data
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_set;
    logic [NREGS-1:0] busy_clr;

    logic [IW-1:0]    dst_idx;
    logic [IW-1:0]    src1_idx;
    logic [IW-1:0]    src2_idx;
    logic [IW-1:0]    wb_idx;
    logic             is_nop;
    logic             wb_hit;
    logic             src1_haz;
    logic             src2_haz;
    logic             hazard;
    logic             issue;
    logic [XLEN-1:0]  src1_val;
    logic [XLEN-1:0]  src2_val;
    logic [XLEN-1:0]  imm;

    assign dst_idx  = in_instr[20 +: IW];
    assign src1_idx = in_instr[15 +: IW];
    assign src2_idx = in_instr[10 +: IW];
    assign wb_idx   = wb_dst[IW-1:0];
    assign is_nop   = (in_instr[31:25] == 7'h00);
    assign wb_hit   = wb_en && (wb_idx != '0);
    assign imm      = {{(XLEN-10){in_instr[9]}}, in_instr[9:0]};

`ifdef DECODE_WB_BYPASS_EN
    // A source released by this cycle's writeback is not a hazard; its value is forwarded.
    assign src1_haz = busy[src1_idx] && !(wb_en && (wb_idx == src1_idx));
    assign src2_haz = busy[src2_idx] && !(wb_en && (wb_idx == src2_idx));

    always_comb begin
        src1_val = regs[src1_idx];
        src2_val = regs[src2_idx];
        if (wb_hit && (wb_idx == src1_idx)) src1_val = wb_data;
        if (wb_hit && (wb_idx == src2_idx)) src2_val = wb_data;
    end
`else
    assign src1_haz = busy[src1_idx];
    assign src2_haz = busy[src2_idx];

    always_comb begin
        src1_val = regs[src1_idx];
        src2_val = regs[src2_idx];
    end
`endif

    assign hazard   = !is_nop && (src1_haz || src2_haz || busy[dst_idx]);
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (wb_en) busy_clr[wb_idx] = 1'b1;
        if (issue && !is_nop && (dst_idx != '0)) busy_set[dst_idx] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-cycle issue keeps its new busy bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= (busy & ~busy_clr) | busy_set;
    end

    // regs[0] is never written, so it reads as zero without a special case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_idx] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_dst      <= '0;
            out_src1_val <= '0;
            out_src2_val <= '0;
            out_offsetlo <= '0;
            out_imm      <= '0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_opcode   <= in_instr[31:25];
            out_dst      <= in_instr[24:20];
            out_src1_val <= src1_val;
            out_src2_val <= src2_val;
            out_offsetlo <= in_instr[9:0];
            out_imm      <= imm;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then random traffic against a
// behavioural model of register file, busy set and output slot.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [6:0]      out_opcode;
    logic [4:0]      out_dst;
    logic [XLEN-1:0] out_src1_val;
    logic [XLEN-1:0] out_src2_val;
    logic [9:0]      out_offsetlo;
    logic [XLEN-1:0] out_imm;
    logic            wb_en = 1'b0;
    logic [4:0]      wb_dst = '0;
    logic [XLEN-1:0] wb_data = '0;

    decode_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_dst(out_dst),
        .out_src1_val(out_src1_val), .out_src2_val(out_src2_val),
        .out_offsetlo(out_offsetlo), .out_imm(out_imm),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  dst;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [9:0]  off;
        logic [31:0] imm;
    } bundle_t;

    bundle_t     q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mregs[NREGS];
    bit          mbusy[NREGS];
    bit          mvalid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2, input int off);
        logic [31:0] w;
        w = {op[6:0], d[4:0], s1[4:0], s2[4:0], off[9:0]};
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
        mvalid = 1'b0;
        q.delete();
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock of stimulus; the model predicts in_ready/out_valid and queues the issued bundle.
    task automatic cycle(input bit v, input logic [31:0] instr, input bit ordy,
                         input bit we, input int wd, input logic [31:0] wdat, output bit issued);
        int op, d, s1, s2, wi;
        bit nop, haz, h1, h2, exp_ready;
        bundle_t b;
        @(negedge clk);
        in_valid = v; in_instr = instr; out_ready = ordy;
        wb_en = we; wb_dst = wd[4:0]; wb_data = wdat;
        #2;
        op = int'(instr[31:25]);
        d  = int'(instr[24:20]) % NREGS;
        s1 = int'(instr[19:15]) % NREGS;
        s2 = int'(instr[14:10]) % NREGS;
        wi = wd % NREGS;
        nop = (op == 0);
        h1 = mbusy[s1] && !(BYPASS && we && wi == s1);
        h2 = mbusy[s2] && !(BYPASS && we && wi == s2);
        haz = !nop && (h1 || h2 || mbusy[d]);
        exp_ready = !haz && (!mvalid || ordy);
        chk("out_valid", 64'(out_valid), 64'(mvalid));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        issued = v && exp_ready;
        if (issued) begin
            b.op  = instr[31:25];
            b.dst = instr[24:20];
            b.s1  = (s1 == 0) ? 32'd0 : ((BYPASS && we && wi == s1) ? wdat : mregs[s1]);
            b.s2  = (s2 == 0) ? 32'd0 : ((BYPASS && we && wi == s2) ? wdat : mregs[s2]);
            b.off = instr[9:0];
            b.imm = 32'(signed'(instr[9:0]));
            q.push_back(b);
        end
        if (issued) mvalid = 1'b1;
        else if (ordy) mvalid = 1'b0;
        if (we) mbusy[wi] = 1'b0;
        if (issued && !nop && d != 0) mbusy[d] = 1'b1;
        if (we && wi != 0) mregs[wi] = wdat;
    endtask

    // Monitor: checks accepted bundles against the queue and stability under backpressure.
    bit          hold = 1'b0;
    logic [6:0]  h_op;
    logic [4:0]  h_dst;
    logic [31:0] h_s1, h_s2, h_imm;
    logic [9:0]  h_off;
    always @(negedge clk) begin
        bundle_t e;
        #3;
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_op",  64'(out_opcode),   64'(h_op));
                chk("hold_dst", 64'(out_dst),      64'(h_dst));
                chk("hold_s1",  64'(out_src1_val), 64'(h_s1));
                chk("hold_s2",  64'(out_src2_val), 64'(h_s2));
                chk("hold_off", 64'(out_offsetlo), 64'(h_off));
                chk("hold_imm", 64'(out_imm),      64'(h_imm));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_bundle", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("opcode",   64'(out_opcode),   64'(e.op));
                    chk("dst",      64'(out_dst),      64'(e.dst));
                    chk("src1_val", 64'(out_src1_val), 64'(e.s1));
                    chk("src2_val", 64'(out_src2_val), 64'(e.s2));
                    chk("offsetlo", 64'(out_offsetlo), 64'(e.off));
                    chk("imm",      64'(out_imm),      64'(e.imm));
                end
            end
            hold  = out_valid && !out_ready;
            h_op  = out_opcode;   h_dst = out_dst;
            h_s1  = out_src1_val; h_s2  = out_src2_val;
            h_off = out_offsetlo; h_imm = out_imm;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit iss;
        int wd;
        int busy_list[$];
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_imm", 64'(out_imm), 64'(0));

        // Basic decode with two written operands and an all-ones offset.
        cycle(0, '0, 1, 1, 1, 32'd5, iss);
        cycle(0, '0, 1, 1, 12, 32'd7, iss);
        cycle(1, mk(1, 3, 1, 12, 10'h3FF), 1, 0, 0, 0, iss);
        cycle(0, '0, 1, 0, 0, 0, iss);

        // RAW stall released by writeback of r3.
        cycle(0, '0, 1, 1, 3, 32'd1, iss);
        cycle(1, mk(1, 3, 0, 0, 0), 1, 0, 0, 0, iss);
        cycle(1, mk(2, 4, 3, 0, 0), 1, 0, 0, 0, iss);
        cycle(1, mk(2, 4, 3, 0, 0), 1, 0, 0, 0, iss);
        cycle(1, mk(2, 4, 3, 0, 0), 1, 1, 3, 32'd9, iss);
        if (!iss) cycle(1, mk(2, 4, 3, 0, 0), 1, 0, 0, 0, iss);
        cycle(0, '0, 1, 1, 4, 32'd2, iss);

        // Backpressure for three cycles, then release.
        cycle(1, mk(3, 0, 0, 0, 5), 0, 0, 0, 0, iss);
        for (int i = 0; i < 3; i++) cycle(1, mk(4, 0, 0, 0, 6), 0, 0, 0, 0, iss);
        cycle(1, mk(4, 0, 0, 0, 6), 1, 0, 0, 0, iss);
        cycle(0, '0, 1, 0, 0, 0, iss);

        // Writes to r0 are dropped.
        cycle(0, '0, 1, 1, 0, 32'hFF, iss);
        cycle(1, mk(5, 0, 0, 0, 1), 1, 0, 0, 0, iss);

        // NOP ignores a busy source; reset clears a pending stall.
        cycle(1, mk(1, 5, 0, 0, 0), 1, 0, 0, 0, iss);
        cycle(1, mk(0, 0, 5, 5, 0), 1, 0, 0, 0, iss);
        cycle(1, mk(1, 6, 5, 0, 0), 1, 0, 0, 0, iss);
        do_reset();
        cycle(1, mk(1, 6, 5, 0, 0), 1, 0, 0, 0, iss);
        cycle(0, '0, 1, 1, 6, 32'd3, iss);

        // Independent stream.
        for (int i = 0; i < 8; i++) cycle(1, mk(i + 8, 16 + i, 9, 10, i * 37), 1, 0, 0, 0, iss);
        cycle(0, '0, 1, 0, 0, 0, iss);

        // Random traffic; writebacks mostly target busy registers so stalls resolve.
        for (int n = 0; n < 600; n++) begin
            int op, d, s1, s2;
            bit we;
            if (n == 300) do_reset();
            op = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127);
            d  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            s1 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            s2 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            busy_list.delete();
            for (int r = 0; r < NREGS; r++) if (mbusy[r]) busy_list.push_back(r);
            we = ($urandom_range(0, 2) == 0);
            if (busy_list.size() != 0 && $urandom_range(0, 9) < 7)
                wd = busy_list[$urandom_range(0, busy_list.size() - 1)];
            else
                wd = $urandom_range(0, 31);
            cycle($urandom_range(0, 3) != 0, mk(op, d, s1, s2, $urandom_range(0, 1023)),
                  $urandom_range(0, 3) != 0, we, wd, $urandom, iss);
        end

        for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0, 0, 0, iss);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
